// File: rtl/tone_seq_player.sv
// tone_seq_player: multi-alarm piezo tone sequencer. Each alarm owns SLOTS
// {half_period, duration} entries that are played forward or reversed, with a
// programmable silent gap between repeats while the request stays high.
module tone_seq_player #(
    parameter int  N_ALARMS   = 4,
    parameter int  SLOTS      = 8,
    parameter int  HP_W       = 16,
    parameter int  DUR_W      = 8,
    parameter int  DUR_SHIFT  = 16,
    parameter int  REPEAT_CYC = 150000000,
    parameter int  TMR_STEP   = 1,
    localparam int ADDR_W     = $clog2(N_ALARMS * SLOTS),
    localparam int ID_W       = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_ALARMS-1:0]   alarm_req,
    input  logic [N_ALARMS-1:0]   alarm_rev,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [HP_W+DUR_W-1:0] wr_data,
    output logic                  piezo,
    output logic                  piezo_n,
    output logic                  busy,
    output logic [ID_W-1:0]       active_id
);

    localparam int SLOT_W = $clog2(SLOTS);
    localparam int ENT_W  = HP_W + DUR_W;
    localparam int DEPTH  = N_ALARMS * SLOTS;
    localparam int DC_W   = DUR_W + DUR_SHIFT;
    localparam int GAP_W  = $clog2(REPEAT_CYC + 1);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(SLOTS - 1);
    localparam logic [HP_W:0]     STEP_T    = (HP_W + 1)'(TMR_STEP);
    localparam logic [DC_W:0]     STEP_D    = (DC_W + 1)'(TMR_STEP);
    localparam logic [GAP_W:0]    STEP_G    = (GAP_W + 1)'(TMR_STEP);
    localparam logic [GAP_W:0]    GAP_LIM   = (GAP_W + 1)'(REPEAT_CYC);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

    state_t              state_q;
    logic [ID_W-1:0]     active_id_q;
    logic                rev_q;
    logic [SLOT_W-1:0]   idx_q;
    logic [ADDR_W-1:0]   ram_addr_q;
    logic [HP_W-1:0]     hp_q;
    logic [DUR_W-1:0]    dur_q;
    logic [HP_W-1:0]     tone_cnt_q;
    logic [DC_W-1:0]     dur_cnt_q;
    logic [GAP_W-1:0]    gap_cnt_q;
    logic                piezo_q;

    logic [ENT_W-1:0]    table_mem [DEPTH];
    logic [ENT_W-1:0]    ram_rdata;
    logic [HP_W-1:0]     ent_hp;
    logic [DUR_W-1:0]    ent_dur;

    logic [ID_W-1:0]     winner;
    logic                any_req, active_req, preempt, do_launch;
    logic [ID_W-1:0]     launch_id;
    logic                launch_rev;
    logic [SLOT_W-1:0]   launch_idx, idx_step;
    logic                idx_last;
    logic [HP_W:0]       tone_sum;
    logic [DC_W:0]       dur_sum, dur_lim;
    logic [GAP_W:0]      gap_sum;
    logic                tone_hit, dur_hit, gap_hit;

    function automatic logic [ADDR_W-1:0] addr_of(input logic [ID_W-1:0] id,
                                                  input logic [SLOT_W-1:0] idx);
        return ADDR_W'({id, idx});
    endfunction

    // Note table write port; the read address is registered by the FSM, giving a 1-cycle read.
    // NOTE: the table is deliberately left out of reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (wr_en) table_mem[wr_addr] <= wr_data;
    end

    assign ram_rdata = table_mem[ram_addr_q];
    assign ent_hp    = ram_rdata[ENT_W-1:DUR_W];
    assign ent_dur   = ram_rdata[DUR_W-1:0];

    // Priority pick: lowest set request bit wins.
    always_comb begin
        // NOTE: default first so every path assigns winner and no latch is inferred.
        winner = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (alarm_req[i]) winner = ID_W'(i);
        end
    end

    assign any_req    = |alarm_req;
    assign active_req = alarm_req[active_id_q];
    assign preempt    = (state_q != S_IDLE) && any_req && (winner < active_id_q);
    assign do_launch  = ((state_q == S_IDLE) && any_req) || preempt ||
                        ((state_q == S_GAP) && active_req && gap_hit);

    // A fresh start takes the winner; a repeat from GAP keeps the owner but re-reads its direction.
    assign launch_id  = ((state_q == S_IDLE) || preempt) ? winner : active_id_q;
    assign launch_rev = alarm_rev[launch_id];
    assign launch_idx = launch_rev ? LAST_SLOT : '0;

    assign idx_step = rev_q ? idx_q - SLOT_W'(1) : idx_q + SLOT_W'(1);
    assign idx_last = rev_q ? (idx_q == '0) : (idx_q == LAST_SLOT);

    // Full-width compares against "count + step" so the hit lands on the last cycle of each interval.
    assign tone_sum = {1'b0, tone_cnt_q} + STEP_T;
    assign dur_sum  = {1'b0, dur_cnt_q} + STEP_D;
    assign dur_lim  = (DC_W + 1)'(dur_q) << DUR_SHIFT;
    assign gap_sum  = {1'b0, gap_cnt_q} + STEP_G;
    assign tone_hit = tone_sum >= {1'b0, hp_q};
    assign dur_hit  = dur_sum >= dur_lim;
    assign gap_hit  = gap_sum >= GAP_LIM;

    // Sequencer FSM: launch/preempt/drop take priority, then per-state stepping and tone generation.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout so every register sees the pre-edge values.
        if (rst) begin
            state_q     <= S_IDLE;
            active_id_q <= '0;
            rev_q       <= 1'b0;
            idx_q       <= '0;
            ram_addr_q  <= '0;
            hp_q        <= '0;
            dur_q       <= '0;
            tone_cnt_q  <= '0;
            dur_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            piezo_q     <= 1'b0;
        end else if (do_launch) begin
            active_id_q <= launch_id;
            rev_q       <= launch_rev;
            idx_q       <= launch_idx;
            ram_addr_q  <= addr_of(launch_id, launch_idx);
            piezo_q     <= 1'b0;
            state_q     <= S_LOAD;
        end else if ((state_q != S_IDLE) && !active_req) begin
            active_id_q <= '0;
            piezo_q     <= 1'b0;
            state_q     <= S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: piezo_q <= 1'b0;
                S_LOAD: begin
                    hp_q       <= ent_hp;
                    dur_q      <= ent_dur;
                    tone_cnt_q <= '0;
                    dur_cnt_q  <= '0;
                    piezo_q    <= 1'b0;
                    if (ent_dur != '0) begin
                        state_q <= S_PLAY;
                    end else if (!rev_q || idx_last) begin
                        // Forward terminator, or reverse scan ran out of slots.
                        gap_cnt_q <= '0;
                        state_q   <= S_GAP;
                    end else begin
                        // Reverse skip of an empty slot: one more LOAD cycle.
                        idx_q      <= idx_step;
                        ram_addr_q <= addr_of(active_id_q, idx_step);
                    end
                end
                S_PLAY: begin
                    if (dur_hit) begin
                        piezo_q    <= 1'b0;
                        tone_cnt_q <= '0;
                        if (idx_last) begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end else begin
                            idx_q      <= idx_step;
                            ram_addr_q <= addr_of(active_id_q, idx_step);
                            state_q    <= S_LOAD;
                        end
                    end else begin
                        dur_cnt_q <= dur_sum[DC_W-1:0];
                        if (tone_hit) begin
                            tone_cnt_q <= '0;
                            piezo_q    <= (hp_q != '0) && !piezo_q;
                        end else begin
                            tone_cnt_q <= tone_sum[HP_W-1:0];
                        end
                    end
                end
                S_GAP: gap_cnt_q <= gap_sum[GAP_W-1:0];
            endcase
        end
    end

    assign piezo     = piezo_q;
    assign piezo_n   = ~piezo_q;
    assign busy      = (state_q != S_IDLE);
    assign active_id = active_id_q;

endmodule

// File: tb/tb_tone_seq_player.sv
// tb_tone_seq_player: directed bench for tone_seq_player with a small note table,
// DUR_SHIFT=4 and a 50-cycle repeat gap; expected values go through a scoreboard queue.
module tb_tone_seq_player;

    localparam int N_ALARMS = 4;
    localparam int SLOTS    = 8;
    localparam int HP_W     = 16;
    localparam int DUR_W    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alarm_req;
    logic [3:0]  alarm_rev;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [23:0] wr_data;
    logic        piezo, piezo_n, busy;
    logic [1:0]  active_id;

    int          n_vec = 0;
    int          n_err = 0;
    int          edges = 0;
    logic        prev_piezo = 1'b0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    tone_seq_player #(
        .N_ALARMS  (N_ALARMS),
        .SLOTS     (SLOTS),
        .HP_W      (HP_W),
        .DUR_W     (DUR_W),
        .DUR_SHIFT (4),
        .REPEAT_CYC(50),
        .TMR_STEP  (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .alarm_req(alarm_req),
        .alarm_rev(alarm_rev),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .piezo    (piezo),
        .piezo_n  (piezo_n),
        .busy     (busy),
        .active_id(active_id)
    );

    always #5 clk = ~clk;

    // Advance n clocks; everything is sampled and driven 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (piezo !== prev_piezo) edges++;
            prev_piezo = piezo;
        end
    endtask

    task automatic expect_val(input string tag, input logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic check(input logic [31:0] obs);
        string       tag;
        logic [31:0] exp_v;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_err++;
            $error("FAIL scoreboard_empty: observed %0h with no expectation queued", obs);
        end else begin
            tag   = tag_q.pop_front();
            exp_v = exp_q.pop_front();
            assert (obs === exp_v) else begin
                n_err++;
                $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] v);
        expect_val(tag, v);
        check(obs);
    endtask

    // The piezo must be low after n-1 clocks and high after the n-th.
    task automatic expect_rise(input string tag, input int n);
        tick(n - 1);
        chk({tag, "_lo"}, {31'b0, piezo}, 32'd0);
        tick(1);
        chk({tag, "_hi"}, {31'b0, piezo}, 32'd1);
    endtask

    task automatic wr(input int id, input int slot, input int hp, input int dur);
        wr_en   = 1'b1;
        wr_addr = 5'(id * SLOTS + slot);
        wr_data = {16'(hp), 8'(dur)};
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"},    {31'b0, busy},    32'd0);
        chk({tag, "_piezo"},   {31'b0, piezo},   32'd0);
        chk({tag, "_piezo_n"}, {31'b0, piezo_n}, 32'd1);
        chk({tag, "_id"},      {30'b0, active_id}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; alarm_req = '0; alarm_rev = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        tick(3);
        chk_idle("reset");
        rst = 1'b0;

        // Single 1600-cycle note at half-period 100, then one repeat after the gap.
        wr(0, 0, 100, 100);
        wr(0, 1, 0, 0);
        alarm_req = 4'b0001;
        tick(1);
        chk("t1_busy", {31'b0, busy}, 32'd1);
        chk("t1_id", {30'b0, active_id}, 32'd0);
        chk("t1_load_piezo", {31'b0, piezo}, 32'd0);
        edges = 0;
        expect_rise("t1_first", 101);
        tick(1500);
        chk("t1_note_end_piezo", {31'b0, piezo}, 32'd0);
        chk("t1_edges", 32'(edges), 32'd16);
        tick(1);
        chk("t1_gap_busy", {31'b0, busy}, 32'd1);
        chk("t1_gap_piezo_n", {31'b0, piezo_n}, 32'd1);
        expect_rise("t1_repeat", 151);
        chk("t1_piezo_n_hi", {31'b0, piezo_n}, 32'd0);
        alarm_req = 4'b0000;
        tick(1);
        chk_idle("t1_drop_play");

        // Three-note forward sequence with terminator, gap, replay from slot 0.
        wr(1, 0, 6, 2);
        wr(1, 1, 5, 2);
        wr(1, 2, 4, 2);
        for (int s = 3; s < SLOTS; s++) wr(1, s, 0, 0);
        alarm_req = 4'b0010;
        tick(1);
        chk("t2_id", {30'b0, active_id}, 32'd1);
        expect_rise("t2_n0", 7);
        tick(26);
        expect_rise("t2_n1", 6);
        tick(27);
        expect_rise("t2_n2", 5);
        tick(28);
        tick(1);
        chk("t2_gap_busy", {31'b0, busy}, 32'd1);
        chk("t2_gap_piezo", {31'b0, piezo}, 32'd0);
        expect_rise("t2_replay", 57);
        alarm_req = 4'b0000;
        tick(1);
        chk("t2_idle_busy", {31'b0, busy}, 32'd0);

        // Same table reversed: five empty-slot skips, then E7, C7, G6, then gap.
        alarm_rev = 4'b0010;
        alarm_req = 4'b0010;
        tick(1);
        chk("t3_id", {30'b0, active_id}, 32'd1);
        alarm_rev = 4'b0000;  // direction was captured at sequence start
        expect_rise("t3_n2", 10);
        tick(28);
        expect_rise("t3_n1", 6);
        tick(27);
        expect_rise("t3_n0", 7);
        tick(26);
        chk("t3_gap_busy", {31'b0, busy}, 32'd1);
        chk("t3_gap_piezo", {31'b0, piezo}, 32'd0);
        tick(10);
        alarm_req = 4'b0000;
        tick(1);
        chk_idle("t3_drop_gap");

        // Table write while the entry plays is heard only on the next repeat, then preemption and reset.
        wr(2, 0, 10, 4);
        wr(2, 1, 0, 0);
        alarm_req = 4'b0100;
        tick(1);
        chk("t4_id", {30'b0, active_id}, 32'd2);
        tick(1);
        wr(2, 0, 7, 4);
        expect_rise("t4_old_hp", 9);
        expect_rise("t4_new_hp", 113);
        alarm_req = 4'b0101;
        tick(1);
        chk("t4_pre_piezo", {31'b0, piezo}, 32'd0);
        chk("t4_pre_id", {30'b0, active_id}, 32'd0);
        chk("t4_pre_busy", {31'b0, busy}, 32'd1);
        expect_rise("t4_pre_note", 101);
        tick(20);
        chk("t4_hold_id", {30'b0, active_id}, 32'd0);
        chk("t4_mid_piezo", {31'b0, piezo}, 32'd1);
        rst = 1'b1;
        tick(1);
        chk_idle("t4_rst");
        alarm_req = 4'b0000;
        tick(1);
        rst = 1'b0;

        // Rest (half-period 0) keeps the piezo silent, then a short tone follows.
        wr(3, 0, 0, 2);
        wr(3, 1, 3, 1);
        wr(3, 2, 0, 0);
        alarm_req = 4'b1000;
        tick(1);
        chk("t5_id", {30'b0, active_id}, 32'd3);
        edges = 0;
        tick(33);
        chk("t5_rest_edges", 32'(edges), 32'd0);
        expect_rise("t5_after_rest", 4);
        alarm_req = 4'b0000;
        tick(1);
        chk("t5_idle_busy", {31'b0, busy}, 32'd0);

        // Owner drops in the same cycle a higher-priority alarm requests: preemption wins.
        alarm_req = 4'b0100;
        tick(5);
        alarm_req = 4'b0001;
        tick(1);
        chk("t6_id", {30'b0, active_id}, 32'd0);
        chk("t6_busy", {31'b0, busy}, 32'd1);
        chk("t6_piezo", {31'b0, piezo}, 32'd0);
        expect_rise("t6_note", 101);
        alarm_req = 4'b0000;
        tick(1);
        chk_idle("t6_end");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
